// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared states, opcodes, select encodings and ALU codes for the multicycle control unit
package mc_ctrl_pkg;

   typedef enum logic [4:0] {
      S_FETCH,
      S_DECODE,
      S_RTYPE,
      S_RWRITE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_IMM,
      S_IMMWB,
      S_JAL1,
      S_JAL2,
      S_JR,
      S_JUMP,
      S_BEQ,
      S_BNE,
      S_IN,
      S_OUT,
      S_TRAP,
      S_HALT
   } ctrlState_t;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ADDI  = 4'h1;
   localparam logic [3:0] OP_LW    = 4'h2;
   localparam logic [3:0] OP_SW    = 4'h3;
   localparam logic [3:0] OP_ORI   = 4'h4;
   localparam logic [3:0] OP_ANDI  = 4'h5;
   localparam logic [3:0] OP_BEQ   = 4'h7;
   localparam logic [3:0] OP_BNE   = 4'h8;
   localparam logic [3:0] OP_JUMP  = 4'h9;
   localparam logic [3:0] OP_JAL   = 4'hA;
   localparam logic [3:0] OP_JR    = 4'hB;
   localparam logic [3:0] OP_IO    = 4'hC;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_JUMP   = 2'd1;
   localparam logic [1:0] PC_BRANCH = 2'd2;
   localparam logic [1:0] PC_TRAP   = 2'd3;

   localparam logic [1:0] M2R_MEM = 2'd0;
   localparam logic [1:0] M2R_ALU = 2'd1;
   localparam logic [1:0] M2R_IN  = 2'd2;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b011;

   // True on the cycle whose closing edge completes an instruction
   function automatic logic retires(input ctrlState_t s, input logic memReady, input logic inValid);
      case (s)
         S_RWRITE, S_IMMWB, S_MEMWB, S_JAL2, S_JUMP, S_JR,
         S_BEQ, S_BNE, S_OUT, S_TRAP: return 1'b1;
         S_MEMWR:                     return memReady;
         S_IN:                        return inValid;
         default:                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: maps opcode/function field to the DECODE dispatch target and the immediate ALU code
module mc_ctrl_decode import mc_ctrl_pkg::*; #(
   parameter int FUNCT_W = 3,
   parameter int TRAP_EN = 1
)(
   input  logic [3:0]         Opcode,
   input  logic [FUNCT_W-1:0] funk,
   output ctrlState_t         dispatch,
   output logic [2:0]         immAluOp
);

   // Dispatch target; unused opcodes either trap or fall back to FETCH as a NOP
   always_comb begin
      dispatch = S_FETCH;
      case (Opcode)
         OP_RTYPE:                 dispatch = S_RTYPE;
         OP_ADDI, OP_ORI, OP_ANDI: dispatch = S_IMM;
         OP_LW, OP_SW:             dispatch = S_MEMADR;
         OP_BEQ:                   dispatch = S_BEQ;
         OP_BNE:                   dispatch = S_BNE;
         OP_JUMP:                  dispatch = S_JUMP;
         OP_JAL:                   dispatch = S_JAL1;
         OP_JR:                    dispatch = S_JR;
         OP_IO:                    dispatch = (funk == FUNCT_W'(1)) ? S_IN : S_OUT;
         OP_HALT:                  dispatch = S_HALT;
         default:                  dispatch = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
      endcase
   end

   // Immediate ALU operation: ori -> OR, andi -> AND, everything else adds
   always_comb begin
      immAluOp = (Opcode == OP_ORI) ? ALU_OR : (Opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
   end

endmodule

// File: rtl/mc_control_unit_v2.sv
// mc_control_unit_v2: multicycle Moore control FSM with wait-state handshakes, trap, halt and retire counter
module mc_control_unit_v2 import mc_ctrl_pkg::*; #(
   parameter int ALUOP_W = 3,
   parameter int FUNCT_W = 3,
   parameter int CNT_W   = 16,
   parameter int TRAP_EN = 1
)(
   input  logic               CLK,
   input  logic               Reset_n,
   input  logic [3:0]         Opcode,
   input  logic [FUNCT_W-1:0] funk,
   input  logic               MemReady,
   input  logic               InValid,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               SrcA,
   output logic [1:0]         SrcB,
   output logic [1:0]         MemtoReg,
   output logic [1:0]         RegDest,
   output logic [1:0]         PCSrc,
   output logic               MemSrc,
   output logic               RegWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               OutputWrite,
   output logic               BranchCond,
   output logic               BranchNECond,
   output logic               IllegalOp,
   output logic               Halted,
   output logic [CNT_W-1:0]   InstrCount
);

   ctrlState_t state;
   ctrlState_t nextState;
   ctrlState_t dispatch;
   logic [2:0] immAluOp;

   mc_ctrl_decode #(
      .FUNCT_W (FUNCT_W),
      .TRAP_EN (TRAP_EN)
   ) uDecode (
      .Opcode   (Opcode),
      .funk     (funk),
      .dispatch (dispatch),
      .immAluOp (immAluOp)
   );

   // State register
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) state <= S_FETCH;
      else          state <= nextState;
   end

   // Next state; memory and input states hold until their handshake completes
   always_comb begin
      nextState = S_FETCH;
      case (state)
         S_FETCH:  nextState = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: nextState = dispatch;
         S_RTYPE:  nextState = S_RWRITE;
         S_MEMADR: nextState = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  nextState = MemReady ? S_MEMWB : S_MEMRD;
         S_MEMWR:  nextState = MemReady ? S_FETCH : S_MEMWR;
         S_IMM:    nextState = S_IMMWB;
         S_JAL1:   nextState = S_JAL2;
         S_IN:     nextState = InValid ? S_FETCH : S_IN;
         S_HALT:   nextState = S_HALT;
         default:  nextState = S_FETCH;
      endcase
   end

   // Moore output decode, held at zero while reset is asserted so nothing leaks out of FETCH
   always_comb begin
      ALUOp        = '0;
      SrcA         = 1'b0;
      SrcB         = 2'd0;
      MemtoReg     = 2'd0;
      RegDest      = 2'd0;
      PCSrc        = 2'd0;
      MemSrc       = 1'b0;
      RegWrite     = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      OutputWrite  = 1'b0;
      BranchCond   = 1'b0;
      BranchNECond = 1'b0;
      Halted       = 1'b0;
      if (Reset_n) begin
         case (state)
            S_FETCH: begin
               MemRead = 1'b1;
               SrcB    = 2'd1;
               ALUOp   = ALUOP_W'(ALU_ADD);
               PCSrc   = PC_ALU;
               IRWrite = MemReady;
               PCWrite = MemReady;
            end
            S_DECODE: begin
               SrcB  = 2'd2;
               ALUOp = ALUOP_W'(ALU_ADD);
            end
            S_RTYPE: begin
               SrcA  = 1'b1;
               ALUOp = funk[ALUOP_W-1:0];
            end
            S_RWRITE: begin
               RegWrite = 1'b1;
               MemtoReg = M2R_ALU;
               RegDest  = RD_RD;
            end
            S_IMM: begin
               SrcA  = 1'b1;
               SrcB  = 2'd2;
               ALUOp = ALUOP_W'(immAluOp);
            end
            S_IMMWB: begin
               RegWrite = 1'b1;
               MemtoReg = M2R_ALU;
               RegDest  = RD_RT;
            end
            S_MEMADR: begin
               SrcA  = 1'b1;
               SrcB  = 2'd2;
               ALUOp = ALUOP_W'(ALU_ADD);
            end
            S_MEMRD: begin
               MemRead = 1'b1;
               MemSrc  = 1'b1;
            end
            S_MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = M2R_MEM;
               RegDest  = RD_RT;
            end
            S_MEMWR: begin
               MemWrite = 1'b1;
               MemSrc   = 1'b1;
            end
            S_JAL1: begin
               SrcB  = 2'd1;
               ALUOp = ALUOP_W'(ALU_ADD);
            end
            S_JAL2: begin
               RegWrite = 1'b1;
               RegDest  = RD_RA;
               MemtoReg = M2R_ALU;
               PCWrite  = 1'b1;
               PCSrc    = PC_JUMP;
            end
            S_JUMP: begin
               PCWrite = 1'b1;
               PCSrc   = PC_JUMP;
            end
            S_JR: begin
               SrcA    = 1'b1;
               ALUOp   = ALUOP_W'(ALU_ADD);
               PCWrite = 1'b1;
               PCSrc   = PC_ALU;
            end
            S_BEQ: begin
               SrcA       = 1'b1;
               ALUOp      = ALUOP_W'(ALU_SUB);
               PCSrc      = PC_BRANCH;
               BranchCond = 1'b1;
            end
            S_BNE: begin
               SrcA         = 1'b1;
               ALUOp        = ALUOP_W'(ALU_SUB);
               PCSrc        = PC_BRANCH;
               BranchNECond = 1'b1;
            end
            S_IN: begin
               RegDest  = RD_RD;
               MemtoReg = M2R_IN;
               RegWrite = InValid;
            end
            S_OUT: begin
               OutputWrite = 1'b1;
            end
            S_TRAP: begin
               PCWrite = 1'b1;
               PCSrc   = PC_TRAP;
            end
            S_HALT: begin
               Halted = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Retired-instruction counter and sticky illegal-opcode flag
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         InstrCount <= '0;
         IllegalOp  <= 1'b0;
      end else begin
         if (retires(state, MemReady, InValid)) InstrCount <= InstrCount + CNT_W'(1);
         if (state == S_TRAP) IllegalOp <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mc_control_unit_v2.sv
// tb_mc_control_unit_v2: directed cycle-by-cycle check of the control unit outputs, counter and flags
module tb_mc_control_unit_v2;

   localparam int RW = 128, MR = 64, MW = 32, IR = 16, PC = 8, OW = 4, BC = 2, BN = 1;

   function automatic logic [21:0] mk(input int a, input int sa, input int sb, input int mt,
                                      input int rd, input int pc, input int ms, input int st, input int h);
      return {3'(a), 1'(sa), 2'(sb), 2'(mt), 2'(rd), 2'(pc), 1'(ms), 8'(st), 1'(h)};
   endfunction

   localparam logic [21:0] X_FETCH  = mk(2, 0, 1, 0, 0, 0, 0, MR + IR + PC, 0);
   localparam logic [21:0] X_FSTALL = mk(2, 0, 1, 0, 0, 0, 0, MR, 0);
   localparam logic [21:0] X_DEC    = mk(2, 0, 2, 0, 0, 0, 0, 0, 0);
   localparam logic [21:0] X_RTYPE2 = mk(2, 1, 0, 0, 0, 0, 0, 0, 0);
   localparam logic [21:0] X_RWR    = mk(0, 0, 0, 1, 1, 0, 0, RW, 0);
   localparam logic [21:0] X_IMMADD = mk(2, 1, 2, 0, 0, 0, 0, 0, 0);
   localparam logic [21:0] X_IMMOR  = mk(1, 1, 2, 0, 0, 0, 0, 0, 0);
   localparam logic [21:0] X_IMMAND = mk(0, 1, 2, 0, 0, 0, 0, 0, 0);
   localparam logic [21:0] X_IMMWB  = mk(0, 0, 0, 1, 0, 0, 0, RW, 0);
   localparam logic [21:0] X_MADR   = mk(2, 1, 2, 0, 0, 0, 0, 0, 0);
   localparam logic [21:0] X_MRD    = mk(0, 0, 0, 0, 0, 0, 1, MR, 0);
   localparam logic [21:0] X_MWB    = mk(0, 0, 0, 0, 0, 0, 0, RW, 0);
   localparam logic [21:0] X_MWR    = mk(0, 0, 0, 0, 0, 0, 1, MW, 0);
   localparam logic [21:0] X_JAL1   = mk(2, 0, 1, 0, 0, 0, 0, 0, 0);
   localparam logic [21:0] X_JAL2   = mk(0, 0, 0, 1, 2, 1, 0, RW + PC, 0);
   localparam logic [21:0] X_JUMP   = mk(0, 0, 0, 0, 0, 1, 0, PC, 0);
   localparam logic [21:0] X_JR     = mk(2, 1, 0, 0, 0, 0, 0, PC, 0);
   localparam logic [21:0] X_BEQ    = mk(3, 1, 0, 0, 0, 2, 0, BC, 0);
   localparam logic [21:0] X_BNE    = mk(3, 1, 0, 0, 0, 2, 0, BN, 0);
   localparam logic [21:0] X_INWAIT = mk(0, 0, 0, 2, 1, 0, 0, 0, 0);
   localparam logic [21:0] X_INGO   = mk(0, 0, 0, 2, 1, 0, 0, RW, 0);
   localparam logic [21:0] X_OUT    = mk(0, 0, 0, 0, 0, 0, 0, OW, 0);
   localparam logic [21:0] X_TRAP   = mk(0, 0, 0, 0, 0, 3, 0, PC, 0);
   localparam logic [21:0] X_HALT   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);

   logic CLK = 1'b0;
   logic Reset_n1, Reset_n2;
   logic [3:0] Opcode;
   logic [2:0] funk;
   logic MemReady, InValid;
   logic sel;
   int errors = 0;
   int checks = 0;

   logic [2:0] ALUOp1, ALUOp2;
   logic SrcA1, SrcA2, MemSrc1, MemSrc2;
   logic [1:0] SrcB1, SrcB2, MemtoReg1, MemtoReg2, RegDest1, RegDest2, PCSrc1, PCSrc2;
   logic RegWrite1, MemRead1, MemWrite1, IRWrite1, PCWrite1, OutputWrite1, BranchCond1, BranchNECond1;
   logic RegWrite2, MemRead2, MemWrite2, IRWrite2, PCWrite2, OutputWrite2, BranchCond2, BranchNECond2;
   logic IllegalOp1, IllegalOp2, Halted1, Halted2;
   logic [15:0] InstrCount1;
   logic [3:0] InstrCount2;
   logic [21:0] ctl1, ctl2;

   always #5 CLK = ~CLK;

   mc_control_unit_v2 dut (
      .CLK(CLK), .Reset_n(Reset_n1), .Opcode(Opcode), .funk(funk), .MemReady(MemReady), .InValid(InValid),
      .ALUOp(ALUOp1), .SrcA(SrcA1), .SrcB(SrcB1), .MemtoReg(MemtoReg1), .RegDest(RegDest1), .PCSrc(PCSrc1),
      .MemSrc(MemSrc1), .RegWrite(RegWrite1), .MemRead(MemRead1), .MemWrite(MemWrite1), .IRWrite(IRWrite1),
      .PCWrite(PCWrite1), .OutputWrite(OutputWrite1), .BranchCond(BranchCond1), .BranchNECond(BranchNECond1),
      .IllegalOp(IllegalOp1), .Halted(Halted1), .InstrCount(InstrCount1)
   );

   mc_control_unit_v2 #(.CNT_W(4), .TRAP_EN(0)) dutNoTrap (
      .CLK(CLK), .Reset_n(Reset_n2), .Opcode(Opcode), .funk(funk), .MemReady(MemReady), .InValid(InValid),
      .ALUOp(ALUOp2), .SrcA(SrcA2), .SrcB(SrcB2), .MemtoReg(MemtoReg2), .RegDest(RegDest2), .PCSrc(PCSrc2),
      .MemSrc(MemSrc2), .RegWrite(RegWrite2), .MemRead(MemRead2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
      .PCWrite(PCWrite2), .OutputWrite(OutputWrite2), .BranchCond(BranchCond2), .BranchNECond(BranchNECond2),
      .IllegalOp(IllegalOp2), .Halted(Halted2), .InstrCount(InstrCount2)
   );

   assign ctl1 = {ALUOp1, SrcA1, SrcB1, MemtoReg1, RegDest1, PCSrc1, MemSrc1, RegWrite1, MemRead1, MemWrite1,
                  IRWrite1, PCWrite1, OutputWrite1, BranchCond1, BranchNECond1, Halted1};
   assign ctl2 = {ALUOp2, SrcA2, SrcB2, MemtoReg2, RegDest2, PCSrc2, MemSrc2, RegWrite2, MemRead2, MemWrite2,
                  IRWrite2, PCWrite2, OutputWrite2, BranchCond2, BranchNECond2, Halted2};

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Check the current cycle's outputs with the inputs already applied, then move to the next cycle
   task automatic chk(input string tag, input logic [21:0] exp);
      #1;
      checkEq(tag, 32'(sel ? ctl2 : ctl1), 32'(exp));
      @(posedge CLK);
      #1;
   endtask

   task automatic chkCnt(input string tag, input int n);
      checkEq(tag, sel ? {28'd0, InstrCount2} : {16'd0, InstrCount1}, 32'(n));
   endtask

   task automatic jumpOnce();
      Opcode = 4'h9;
      chk("wrap.fetch", X_FETCH);
      chk("wrap.dec", X_DEC);
      chk("wrap.jump", X_JUMP);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      sel = 1'b0;
      Reset_n1 = 1'b0;
      Reset_n2 = 1'b0;
      Opcode = 4'h0;
      funk = 3'd2;
      MemReady = 1'b1;
      InValid = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      checkEq("reset.ctl", 32'(ctl1), 32'd0);
      chkCnt("reset.cnt", 0);
      checkEq("reset.ill", 32'(IllegalOp1), 32'd0);
      Reset_n1 = 1'b1;
      chk("r.fetch", X_FETCH);
      chk("r.dec", X_DEC);
      chk("r.rtype", X_RTYPE2);
      chk("r.rwrite", X_RWR);
      chkCnt("r.cnt", 1);
      Opcode = 4'h2;
      chk("lw.fetch", X_FETCH);
      chk("lw.dec", X_DEC);
      chk("lw.madr", X_MADR);
      MemReady = 1'b0;
      chk("lw.stall1", X_MRD);
      chk("lw.stall2", X_MRD);
      MemReady = 1'b1;
      chk("lw.memrd", X_MRD);
      chk("lw.memwb", X_MWB);
      chkCnt("lw.cnt", 2);
      Opcode = 4'h3;
      MemReady = 1'b0;
      chk("sw.fstall", X_FSTALL);
      MemReady = 1'b1;
      chk("sw.fetch", X_FETCH);
      chk("sw.dec", X_DEC);
      chk("sw.madr", X_MADR);
      MemReady = 1'b0;
      chk("sw.wstall", X_MWR);
      MemReady = 1'b1;
      chk("sw.wr", X_MWR);
      chkCnt("sw.cnt", 3);
      Opcode = 4'hD;
      chk("trap.fetch", X_FETCH);
      chk("trap.dec", X_DEC);
      chk("trap.trap", X_TRAP);
      checkEq("trap.ill", 32'(IllegalOp1), 32'd1);
      chkCnt("trap.cnt", 4);
      Opcode = 4'hC;
      funk = 3'd1;
      chk("in.fetch", X_FETCH);
      chk("in.dec", X_DEC);
      for (int i = 0; i < 3; i++) chk("in.wait", X_INWAIT);
      InValid = 1'b1;
      chk("in.go", X_INGO);
      chkCnt("in.cnt", 5);
      checkEq("in.ill", 32'(IllegalOp1), 32'd1);
      funk = 3'd0;
      chk("out.fetch", X_FETCH);
      chk("out.dec", X_DEC);
      chk("out.out", X_OUT);
      chkCnt("out.cnt", 6);
      Opcode = 4'h1;
      chk("addi.fetch", X_FETCH);
      chk("addi.dec", X_DEC);
      chk("addi.imm", X_IMMADD);
      chk("addi.wb", X_IMMWB);
      Opcode = 4'h4;
      chk("ori.fetch", X_FETCH);
      chk("ori.dec", X_DEC);
      chk("ori.imm", X_IMMOR);
      chk("ori.wb", X_IMMWB);
      Opcode = 4'h5;
      chk("andi.fetch", X_FETCH);
      chk("andi.dec", X_DEC);
      chk("andi.imm", X_IMMAND);
      chk("andi.wb", X_IMMWB);
      chkCnt("imm.cnt", 9);
      Opcode = 4'hA;
      chk("jal.fetch", X_FETCH);
      chk("jal.dec", X_DEC);
      chk("jal.jal1", X_JAL1);
      chk("jal.jal2", X_JAL2);
      Opcode = 4'hB;
      chk("jr.fetch", X_FETCH);
      chk("jr.dec", X_DEC);
      chk("jr.jr", X_JR);
      Opcode = 4'h7;
      chk("beq.fetch", X_FETCH);
      chk("beq.dec", X_DEC);
      chk("beq.beq", X_BEQ);
      Opcode = 4'h8;
      chk("bne.fetch", X_FETCH);
      chk("bne.dec", X_DEC);
      chk("bne.bne", X_BNE);
      Opcode = 4'h9;
      chk("j.fetch", X_FETCH);
      chk("j.dec", X_DEC);
      chk("j.jump", X_JUMP);
      chkCnt("j.cnt", 14);
      checkEq("j.ill", 32'(IllegalOp1), 32'd1);
      Opcode = 4'h3;
      chk("rst.fetch", X_FETCH);
      chk("rst.dec", X_DEC);
      chk("rst.madr", X_MADR);
      MemReady = 1'b0;
      chk("rst.wstall", X_MWR);
      #1;
      checkEq("rst.mwbefore", 32'(MemWrite1), 32'd1);
      Reset_n1 = 1'b0;
      #1;
      checkEq("rst.ctl", 32'(ctl1), 32'd0);
      chkCnt("rst.cnt", 0);
      checkEq("rst.ill", 32'(IllegalOp1), 32'd0);
      @(posedge CLK);
      #1;
      Reset_n1 = 1'b1;
      MemReady = 1'b1;
      Opcode = 4'h9;
      chk("post.fetch", X_FETCH);
      chk("post.dec", X_DEC);
      chk("post.jump", X_JUMP);
      chkCnt("post.cnt", 1);
      Opcode = 4'hF;
      chk("halt.fetch", X_FETCH);
      chk("halt.dec", X_DEC);
      for (int i = 0; i < 3; i++) chk("halt.halt", X_HALT);
      chkCnt("halt.cnt", 1);
      sel = 1'b1;
      Reset_n1 = 1'b0;
      Reset_n2 = 1'b1;
      Opcode = 4'hD;
      chk("nt.fetch", X_FETCH);
      chk("nt.dec", X_DEC);
      MemReady = 1'b0;
      chk("nt.back", X_FSTALL);
      chkCnt("nt.cnt", 0);
      checkEq("nt.ill", 32'(IllegalOp2), 32'd0);
      MemReady = 1'b1;
      repeat (15) jumpOnce();
      chkCnt("wrap.15", 15);
      jumpOnce();
      chkCnt("wrap.0", 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
